// File: rtl/soc_system_pio_cmd_out_pkg.sv
// ============================================================================
// Module  : soc_system_pio_cmd_out_pkg
// Brief   : Register map, bit indices and FSM encoding for the command PIO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package soc_system_pio_cmd_out_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;

    localparam int ST_VALID = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;

    localparam int CTL_CLR_OVF = 0;
    localparam int CTL_FLUSH   = 1;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_e;

    function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                                input logic empty, input logic valid);
        logic [31:0] w;
        w           = '0;
        w[ST_OVF]   = ovf;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        w[ST_VALID] = valid;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_system_pio_cmd_fifo.sv
// ============================================================================
// Module  : soc_system_pio_cmd_fifo
// Brief   : Synchronous FIFO with push, pop, flush, fill count and flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module soc_system_pio_cmd_fifo #(
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic [CW-1:0]         count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // Flush dominates both ports; a full FIFO rejects a push even alongside a pop.
    assign push_ok = push_i & ~full  & ~flush_i;
    assign pop_ok  = pop_i  & ~empty & ~flush_i;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

`default_nettype wire

// File: rtl/soc_system_pio_cmd_out.sv
// ============================================================================
// Module  : soc_system_pio_cmd_out
// Brief   : Avalon-MM host-to-fabric command PIO with FIFO and valid/ready output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module soc_system_pio_cmd_out
    import soc_system_pio_cmd_out_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  wr_en;
    logic                  push;
    logic                  clr_ovf;
    logic                  flush;
    logic                  pop;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] out_port_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] last_sent_q;
    logic                  overflow_q;
    logic                  overflow_d;
    logic [31:0]           readdata_q;
    logic                  unused_wdata;

    assign wr_en   = chipselect & ~write_n;
    assign push    = wr_en & (address == ADDR_DATA);
    assign clr_ovf = wr_en & (address == ADDR_CTRL) & writedata[CTL_CLR_OVF];
    assign flush   = wr_en & (address == ADDR_CTRL) & writedata[CTL_FLUSH];
    assign xfer    = out_valid_q & out_ready;
    assign pop     = ~flush & ~fifo_empty & ((state_q == S_IDLE) | xfer);

    assign unused_wdata = ^writedata[31:DATA_WIDTH];

    soc_system_pio_cmd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (writedata[DATA_WIDTH-1:0]),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A dropped push sets the flag even if a clear arrives in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (push & fifo_full & ~flush) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
            last_sent_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            if (xfer) begin
                last_sent_q <= out_port_q;
            end
            if (flush) begin
                out_valid_q <= 1'b0;
                state_q     <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!fifo_empty) begin
                            out_port_q  <= fifo_dout;
                            out_valid_q <= 1'b1;
                            state_q     <= S_PRESENT;
                        end
                    end
                    S_PRESENT: begin
                        if (xfer) begin
                            if (!fifo_empty) begin
                                out_port_q <= fifo_dout;
                            end else begin
                                out_valid_q <= 1'b0;
                                state_q     <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            case (address)
                ADDR_DATA:  readdata_q <= 32'(last_sent_q);
                ADDR_CTRL:  readdata_q <= status_word(overflow_q, fifo_full, fifo_empty, out_valid_q);
                ADDR_COUNT: readdata_q <= 32'(fifo_count);
                default:    readdata_q <= '0;
            endcase
        end
    end

    assign readdata  = readdata_q;
    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_pio_cmd_out.sv
// ============================================================================
// Module  : tb_soc_system_pio_cmd_out
// Brief   : Directed vector table plus hand sequences for the command PIO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_soc_system_pio_cmd_out;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] exp_rd;
        logic        exp_vld;
        logic [7:0]  exp_port;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ready;

    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vq[$];
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_port = '0;

    soc_system_pio_cmd_out #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] a, input logic [31:0] d,
                                input logic rdy, input logic [31:0] rd,
                                input logic vld, input logic [7:0] port);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.rdy = rdy;
        v.exp_rd = rd; v.exp_vld = vld; v.exp_port = port;
        return v;
    endfunction

    // Handshake monitor: ordering against the scoreboard and hold-while-stalled.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_port", 32'(out_port), 32'(prev_port));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(out_port), 32'hFFFF_FFFF);
                end else begin
                    chk("order", 32'(out_port), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_port  = out_port;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;

        // {wr, addr, wdata, ready, exp readdata, exp valid, exp port}
        vq.push_back(mk(0, 2'd1, 32'h0,  1, 32'h2,  0, 8'h00)); // reset status
        vq.push_back(mk(0, 2'd2, 32'h0,  1, 32'h0,  0, 8'h00));
        vq.push_back(mk(1, 2'd0, 32'hA5, 1, 32'h0,  0, 8'h00)); // single byte latency
        vq.push_back(mk(0, 2'd1, 32'h0,  1, 32'h0,  1, 8'hA5));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'h0,  0, 8'h00));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'hA5, 0, 8'h00));
        vq.push_back(mk(1, 2'd0, 32'h01, 0, 32'hA5, 0, 8'h00)); // fill with ready low
        vq.push_back(mk(1, 2'd0, 32'h02, 0, 32'hA5, 1, 8'h01));
        vq.push_back(mk(1, 2'd0, 32'h03, 0, 32'hA5, 1, 8'h01));
        vq.push_back(mk(1, 2'd0, 32'h04, 0, 32'hA5, 1, 8'h01));
        vq.push_back(mk(1, 2'd0, 32'h05, 0, 32'hA5, 1, 8'h01));
        vq.push_back(mk(0, 2'd2, 32'h0,  0, 32'h4,  1, 8'h01));
        vq.push_back(mk(0, 2'd1, 32'h0,  0, 32'h5,  1, 8'h01));
        vq.push_back(mk(1, 2'd0, 32'h06, 0, 32'hA5, 1, 8'h01)); // overflowing push
        vq.push_back(mk(0, 2'd1, 32'h0,  0, 32'hD,  1, 8'h01));
        vq.push_back(mk(0, 2'd2, 32'h0,  1, 32'h4,  1, 8'h02)); // back-to-back drain
        vq.push_back(mk(0, 2'd2, 32'h0,  1, 32'h3,  1, 8'h03));
        vq.push_back(mk(0, 2'd2, 32'h0,  1, 32'h2,  1, 8'h04));
        vq.push_back(mk(0, 2'd2, 32'h0,  1, 32'h1,  1, 8'h05));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'h04, 0, 8'h00));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'h05, 0, 8'h00));
        vq.push_back(mk(1, 2'd1, 32'h1,  1, 32'hA,  0, 8'h00)); // clear overflow
        vq.push_back(mk(0, 2'd1, 32'h0,  1, 32'h2,  0, 8'h00));
        vq.push_back(mk(1, 2'd0, 32'h11, 0, 32'h05, 0, 8'h00)); // queue then flush
        vq.push_back(mk(1, 2'd0, 32'h22, 0, 32'h05, 1, 8'h11));
        vq.push_back(mk(1, 2'd0, 32'h33, 0, 32'h05, 1, 8'h11));
        vq.push_back(mk(1, 2'd0, 32'h44, 0, 32'h05, 1, 8'h11));
        vq.push_back(mk(1, 2'd1, 32'h2,  0, 32'h1,  0, 8'h00));
        vq.push_back(mk(0, 2'd2, 32'h0,  0, 32'h0,  0, 8'h00));
        vq.push_back(mk(0, 2'd1, 32'h0,  0, 32'h2,  0, 8'h00));
        vq.push_back(mk(1, 2'd0, 32'h77, 0, 32'h05, 0, 8'h00));
        vq.push_back(mk(0, 2'd0, 32'h0,  0, 32'h05, 1, 8'h77));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'h05, 0, 8'h00));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'h77, 0, 8'h00));
        vq.push_back(mk(1, 2'd0, 32'h5A, 0, 32'h77, 0, 8'h00)); // flush during transfer
        vq.push_back(mk(0, 2'd0, 32'h0,  0, 32'h77, 1, 8'h5A));
        vq.push_back(mk(1, 2'd1, 32'h2,  1, 32'h3,  0, 8'h00));
        vq.push_back(mk(0, 2'd0, 32'h0,  1, 32'h5A, 0, 8'h00));
        vq.push_back(mk(0, 2'd1, 32'h0,  1, 32'h2,  0, 8'h00));

        tick();
        tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_port", 32'(out_port), 32'h0);
        reset = 1'b0;

        foreach (vq[i]) begin
            chipselect = vq[i].wr;
            write_n    = ~vq[i].wr;
            address    = vq[i].addr;
            writedata  = vq[i].wdata;
            out_ready  = vq[i].rdy;
            tick();
            chk($sformatf("v%0d_readdata", i), readdata, vq[i].exp_rd);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].exp_vld));
            if (vq[i].exp_vld) begin
                chk($sformatf("v%0d_port", i), 32'(out_port), 32'(vq[i].exp_port));
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Random backpressure: three bursts that each fit in FIFO + output stage.
        mon_en = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] byte_v;
                byte_v    = 8'(8'h30 + b * 4 + k);
                out_ready = 1'($urandom_range(0, 1));
                exp_q.push_back(byte_v);
                bus_write(2'd0, 32'(byte_v));
            end
            for (int c = 0; c < 200 && (exp_q.size() != 0 || out_valid); c++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            chk($sformatf("drain%0d", b), 32'(exp_q.size()) | 32'(out_valid), 32'h0);
        end
        mon_en    = 1'b0;
        out_ready = 1'b0;
        tick();

        // Reset while a byte is presented and three more are queued.
        bus_write(2'd0, 32'hC1);
        bus_write(2'd0, 32'hC2);
        bus_write(2'd0, 32'hC3);
        bus_write(2'd0, 32'hC4);
        address = 2'd2;
        tick();
        chk("pre_rst_count", readdata, 32'h3);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_port", 32'(out_port), 32'h0);
        chk("async_rst_readdata", readdata, 32'h0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        address   = 2'd1;
        tick();
        chk("post_rst_status", readdata, 32'h2);
        address = 2'd2;
        tick();
        chk("post_rst_count", readdata, 32'h0);
        address = 2'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_valid%0d", c), 32'(out_valid), 32'h0);
        end
        chk("post_rst_last", readdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
